pipeline_stage_elastic: RTL
===========================

// Module: pipeline_stage_elastic
// PURPOSE
//  Parametrised elastic pipeline register for the VLIW core: carries one bundle of SLOTS
//  instruction slots (ALU, MEM, ...) between stages with a valid/ready handshake,
//  optional 2-entry skid buffer, flush, per-slot valid bits and empty-bundle drop.
//  Replaces the fixed-width always-enabled stage registers between IF/ID/EX/MEM/WB.
// PARAMETERS
//  SLOTS       2   issue slots per bundle
//  SLOT_W      64  payload bits per slot (decoded fields, operands, control signals)
//  SKID        1   1: 2-entry skid buffer, registered in_ready; 0: single entry
//  DROP_EMPTY  0   1: accepted bundles with in_slot_valid==0 are discarded, not stored
// PORTS
//  clk             in   1             rising-edge clock
//  reset           in   1             synchronous, active-low reset
//  flush           in   1             discard all held bundles (branch/jump/exception)
//  in_valid        in   1             upstream bundle valid
//  in_ready        out  1             stage can accept a bundle
//  in_slot_valid   in   SLOTS         per-slot valid; bit i qualifies slot i
//  in_data         in   SLOTS*SLOT_W  bundle payload; slot i = [i*SLOT_W +: SLOT_W]
//  out_valid       out  1             held bundle valid
//  out_ready       in   1             downstream accepts bundle
//  out_slot_valid  out  SLOTS         per-slot valid of the head bundle
//  out_data        out  SLOTS*SLOT_W  head bundle payload
//  occupancy       out  2             bundles held (0..2; max 1 when SKID=0)
//  stall_count     out  16            cycles with out_valid && !out_ready, saturating
// BEHAVIOUR
//  - Accept = in_valid && in_ready; Emit = out_valid && out_ready. Order is strict FIFO.
//  - Reset (reset==0 at posedge): out_valid=0, out_slot_valid=0, out_data=0, occupancy=0,
//    stall_count=0, entries empty; in_ready=0 while reset is low, 1 on the first cycle after.
//  - SKID=1: entries HEAD (drives outputs) and SKID. in_ready is a register: 1 iff SKID empty.
//    States EMPTY(0) / ONE(1) / FULL(2):
//    EMPTY: Accept -> HEAD, ONE.
//    ONE: Accept&&Emit -> HEAD<=in, ONE; Accept only -> SKID<=in, FULL;
//         Emit only -> EMPTY.
//    FULL: no Accept possible; Emit -> HEAD<=SKID, ONE.
//    Latency in->out is 1 cycle; full throughput when out_ready stays high.
//  - SKID=0: single entry; in_ready = !out_valid || out_ready (combinational from out_ready);
//    Accept&&Emit in the same cycle replaces HEAD; latency 1.
//  - out_data/out_slot_valid are stable while out_valid && !out_ready (no change until Emit).
//  - DROP_EMPTY=1: an Accept with in_slot_valid==0 is consumed (counts as accepted) but not
//    stored; the state is updated as if only Emit occurred that cycle.
//  - flush=1 at posedge: both entries invalidated, occupancy=0, out_valid=0,
//    out_slot_valid=0, in_ready=1 next cycle; a bundle accepted in the flush cycle is discarded.
//    out_data is not cleared. Flush has priority over Accept/Emit; a downstream Emit in the
//    flush cycle still completes (downstream sampled it).
//  - flush while reset low: reset wins.
//  - stall_count: +1 each cycle out_valid && !out_ready; holds at 16'hFFFF; cleared by
//    reset only (not by flush).
//  - occupancy equals the number of valid entries after the clock edge; never exceeds
//    1+SKID.
// TESTING
//  1 Reset: hold reset=0 3 cycles -> out_valid=0, occupancy=0, stall_count=0, in_ready=0; release -> in_ready=1.
//  2 Streaming: out_ready=1, push bundles A,B,C back-to-back -> out_data=A,B,C on consecutive cycles, each 1 cycle after Accept.
//  3 Backpressure (SKID=1): out_ready=0, push A,B,C -> A at out, B in skid, occupancy=2, in_ready=0, C held upstream;
//    raise out_ready -> A,B,C emitted in order; stall_count equals the number of stalled cycles.
//  4 Flush: occupancy=2, assert flush with in_valid=1 (bundle D) -> next cycle out_valid=0, occupancy=0, in_ready=1; D never appears.
//  5 DROP_EMPTY=1: push A, E (slot_valid=2'b00), B with out_ready=1 -> output A,B only; out_slot_valid matches input per bundle.
//  6 Saturation: out_valid=1, out_ready=0 for 70000 cycles -> stall_count=16'hFFFF; flush does not clear it; reset does.

Source files
------------

// File: rtl/pipeline_stage_elastic.sv
// pipeline_stage_elastic
//   Elastic pipeline register carrying one VLIW bundle (SLOTS slots of SLOT_W bits)
//   between stages with a valid/ready handshake. Optional 2-entry skid buffer with a
//   registered in_ready, flush, per-slot valid bits and optional empty-bundle drop.
// Ports
//   clk, reset (sync, active-low)   clock / reset
//   flush                           discard all held bundles
//   in_valid/in_ready               upstream handshake
//   in_slot_valid, in_data          upstream bundle (slot i = [i*SLOT_W +: SLOT_W])
//   out_valid/out_ready             downstream handshake
//   out_slot_valid, out_data        head bundle
//   occupancy                       bundles held (0..1+SKID)
//   stall_count                     saturating count of out_valid && !out_ready cycles
module pipeline_stage_elastic #(
  parameter int unsigned SLOTS      = 2,
  parameter int unsigned SLOT_W     = 64,
  parameter int unsigned SKID       = 1,
  parameter int unsigned DROP_EMPTY = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SLOTS-1:0]        in_slot_valid,
  input  logic [SLOTS*SLOT_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SLOTS-1:0]        out_slot_valid,
  output logic [SLOTS*SLOT_W-1:0] out_data,
  output logic [1:0]              occupancy,
  output logic [15:0]             stall_count
);

  localparam int unsigned DATA_W = SLOTS * SLOT_W;
  localparam int unsigned CNT_W  = 16;

  typedef struct packed {
    logic [SLOTS-1:0]  sv;
    logic [DATA_W-1:0] data;
  } bundle_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  bundle_t          head_q, head_d;
  bundle_t          skid_q, skid_d;
  bundle_t          in_bundle;
  logic             in_ready_q;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             accept, emit, store;

  assign in_bundle = '{sv: in_slot_valid, data: in_data};

  // Without a skid entry, ready is combinational from out_ready; in_ready_q only
  // masks it while in reset.
  assign in_ready = (SKID != 0) ? in_ready_q
                                : (in_ready_q && (!out_valid || out_ready));

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;
  // An all-empty bundle is consumed but never stored when dropping is enabled.
  assign store  = accept && !((DROP_EMPTY != 0) && (in_slot_valid == '0));

  // State register and entry storage
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != ST_FULL);
      stall_q    <= stall_d;
    end
  end

  // Next-state logic; flush overrides any accept/emit
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (store) state_d = ST_ONE;
        ST_ONE: begin
          if (store && !emit)      state_d = (SKID != 0) ? ST_FULL : ST_ONE;
          else if (!store && emit) state_d = ST_EMPTY;
        end
        ST_FULL:  if (emit) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Entry data movement and stall counter
  always_comb begin
    head_d  = head_q;
    skid_d  = skid_q;
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (flush) begin
      // Payload is left in place; only the slot valids are cleared.
      head_d.sv = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (store) head_d = in_bundle;
        ST_ONE: begin
          if (store && emit) head_d = in_bundle;
          else if (store)    skid_d = in_bundle;
        end
        ST_FULL:  if (emit) head_d = skid_q;
        default:  head_d = head_q;
      endcase
    end
  end

  // Output decode from the state register
  always_comb begin
    out_valid      = (state_q != ST_EMPTY);
    occupancy      = 2'(state_q);
    out_slot_valid = out_valid ? head_q.sv : '0;
    out_data       = head_q.data;
    stall_count    = stall_q;
  end

endmodule
